// File: rtl/bcd_pkg.sv
// Shared definitions for the serial packed-BCD adder/subtractor.
// Contents: FSM state encoding, BCD constants, and the nine's-complement
// helper used to turn a subtraction into an addition.
package bcd_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   localparam logic [3:0] BCD_MAX  = 4'd9;
   localparam logic [3:0] BCD_CORR = 4'd6;

   // 9 - d on the 4-bit value; wraps for non-BCD digits, which is acceptable
   // because such results are undefined as decimal anyway.
   function automatic logic [3:0] nines_comp(input logic [3:0] d);
      return BCD_MAX - d;
   endfunction

endpackage

// File: rtl/bcd_digit_add.sv
// Combinational single-digit BCD adder with decimal correction.
// Ports:
//   a, b   : 4-bit input digits (b already complemented by the parent for sub)
//   cin    : carry in
//   digit  : corrected result digit
//   cout   : decimal carry out
module bcd_digit_add
   import bcd_pkg::*;
(
   input  logic [3:0] a,
   input  logic [3:0] b,
   input  logic       cin,
   output logic [3:0] digit,
   output logic       cout
);

   logic [4:0] bin_sum;

   always_comb begin
      bin_sum = {1'b0, a} + {1'b0, b} + {4'b0000, cin};
      if (bin_sum > {1'b0, BCD_MAX}) begin
         // Skip the six unused codes; the add wraps mod 16 on purpose.
         digit = bin_sum[3:0] + BCD_CORR;
         cout  = 1'b1;
      end else begin
         digit = bin_sum[3:0];
         cout  = 1'b0;
      end
   end

endmodule

// File: rtl/bcd_serial_addsub.sv
// Multi-digit packed-BCD adder/subtractor, one digit per clock, LSD first.
// Optional feature macro: BCD_INVALID_CHECK_EN (flags non-BCD input digits).
// Ports:
//   clk, rst_n           : clock, asynchronous active-low reset
//   in_valid / in_ready  : operand handshake (a, b, sub, cin)
//   out_valid / out_ready: result handshake (sum, cout, err)
//   sub                  : 0 = A+B+cin, 1 = A-B-cin (cin acts as borrow-in)
//   cout                 : carry-out (add) or borrow-out (sub)
//   err                  : non-BCD digit seen at accept (0 when macro undefined)
module bcd_serial_addsub
   import bcd_pkg::*;
#(
   parameter int DIGITS = 4
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic                in_valid,
   output logic                in_ready,
   input  logic [4*DIGITS-1:0] a,
   input  logic [4*DIGITS-1:0] b,
   input  logic                sub,
   input  logic                cin,
   output logic                out_valid,
   input  logic                out_ready,
   output logic [4*DIGITS-1:0] sum,
   output logic                cout,
   output logic                err
);

   localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
   localparam logic [IW-1:0] LAST_IDX = IW'(DIGITS - 1);

   state_t              state_reg;
   logic [IW-1:0]       idx_reg;
   logic                carry_reg;
   logic                sub_reg;
   logic [4*DIGITS-1:0] a_reg;
   logic [4*DIGITS-1:0] b_reg;
   logic [4*DIGITS-1:0] sum_reg;
   logic                cout_reg;

   logic [3:0] a_dig;
   logic [3:0] b_raw;
   logic [3:0] b_dig;
   logic [3:0] core_digit;
   logic       core_cout;

   assign in_ready  = (state_reg == IDLE);
   assign out_valid = (state_reg == DONE);
   assign sum       = sum_reg;
   assign cout      = cout_reg;

   // Digit-slice selection for the current index.
   assign a_dig = a_reg[{idx_reg, 2'b00} +: 4];
   assign b_raw = b_reg[{idx_reg, 2'b00} +: 4];
   assign b_dig = sub_reg ? nines_comp(b_raw) : b_raw;

   bcd_digit_add u_digit (
      .a     (a_dig),
      .b     (b_dig),
      .cin   (carry_reg),
      .digit (core_digit),
      .cout  (core_cout)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_reg <= IDLE;
         idx_reg   <= '0;
         carry_reg <= 1'b0;
         sub_reg   <= 1'b0;
         a_reg     <= '0;
         b_reg     <= '0;
         sum_reg   <= '0;
         cout_reg  <= 1'b0;
      end else begin
         case (state_reg)
            IDLE: begin
               if (in_valid) begin
                  a_reg     <= a;
                  b_reg     <= b;
                  sub_reg   <= sub;
                  // Ten's complement = nine's complement + 1, so an
                  // inactive borrow becomes a carry of 1.
                  carry_reg <= sub ? ~cin : cin;
                  idx_reg   <= '0;
                  state_reg <= RUN;
               end
            end
            RUN: begin
               sum_reg[{idx_reg, 2'b00} +: 4] <= core_digit;
               carry_reg <= core_cout;
               if (idx_reg == LAST_IDX) begin
                  cout_reg  <= sub_reg ? ~core_cout : core_cout;
                  idx_reg   <= '0;
                  state_reg <= DONE;
               end else begin
                  idx_reg <= idx_reg + 1'b1;
               end
            end
            DONE: begin
               if (out_ready) begin
                  state_reg <= IDLE;
               end
            end
            default: state_reg <= IDLE;
         endcase
      end
   end

`ifdef BCD_INVALID_CHECK_EN
   logic [DIGITS-1:0] bad_dig;
   logic              err_reg;

   for (genvar gi = 0; gi < DIGITS; gi++) begin : g_check
      assign bad_dig[gi] = (a[4*gi +: 4] > BCD_MAX) || (b[4*gi +: 4] > BCD_MAX);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         err_reg <= 1'b0;
      end else if (state_reg == IDLE && in_valid) begin
         err_reg <= |bad_dig;
      end
   end

   assign err = err_reg;
`else
   assign err = 1'b0;
`endif

endmodule
